// File: rtl/dpe_operand_feeder.sv
// Operand feeder for the dot-product engine: packs weight/activation beats into
// wide vectors and issues them as a single-cycle pulse gated by downstream credits.
module dpe_operand_feeder #(
  parameter int DATAW   = 512,
  parameter int CHUNKW  = 64,
  parameter int CHUNKS  = DATAW / CHUNKW,
  parameter int CREDITS = 8,
  parameter int CNTW    = $clog2(CHUNKS),
  parameter int CRW     = $clog2(CREDITS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [CHUNKW-1:0] w_data,
  input  logic              w_reload,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [CHUNKW-1:0] a_data,
  input  logic              i_credit_ret,
  output logic              o_valid,
  output logic [DATAW-1:0]  o_dataa,
  output logic [DATAW-1:0]  o_datab,
  output logic [CRW-1:0]    o_credits,
  output logic              o_credit_err
);

  typedef enum logic [1:0] {
    W_LOAD = 2'd0,
    A_PACK = 2'd1,
    ISSUE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [CRW-1:0]    credits_q, credits_d;
  logic              reload_q, reload_d;
  logic              err_q, err_d;
  logic              live_q;
  logic [DATAW-1:0]  wvec_q, avec_q;
  logic [DATAW-1:0]  dataa_q, datab_q;

  logic              w_ready_s, a_ready_s, issue_s;
  logic              w_hs_s, a_hs_s, last_beat_s;

  assign w_hs_s      = w_valid & w_ready_s;
  assign a_hs_s      = a_valid & a_ready_s;
  assign last_beat_s = (cnt_q == CNTW'(CHUNKS - 1));

  // Next-state, beat counter, reload tracking and handshake readies.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    reload_d  = reload_q;
    w_ready_s = 1'b0;
    a_ready_s = 1'b0;
    issue_s   = 1'b0;
    case (state_q)
      W_LOAD: begin
        w_ready_s = live_q;
        if (w_valid && live_q) begin
          if (last_beat_s) begin
            cnt_d    = '0;
            reload_d = 1'b0;
            state_d  = A_PACK;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      A_PACK: begin
        // A reload before the first beat redirects immediately; later it waits for issue.
        if (w_reload && (cnt_q == '0)) begin
          a_ready_s = 1'b0;
          state_d   = W_LOAD;
        end else begin
          a_ready_s = 1'b1;
          reload_d  = reload_q | w_reload;
          if (a_valid) begin
            if (last_beat_s) begin
              cnt_d   = '0;
              state_d = ISSUE;
            end else begin
              cnt_d = cnt_q + CNTW'(1);
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
      end
      ISSUE: begin
        reload_d = reload_q | w_reload;
        if (credits_q != '0) begin
          issue_s = 1'b1;
          state_d = (reload_q || w_reload) ? W_LOAD : A_PACK;
        end else begin
          state_d = ISSUE;
        end
      end
      default: begin
        state_d = W_LOAD;
        cnt_d   = '0;
      end
    endcase
  end

  // Credit accounting; a surplus return is flagged rather than counted.
  always_comb begin
    credits_d = credits_q;
    err_d     = err_q;
    if (issue_s && !i_credit_ret) begin
      credits_d = credits_q - CRW'(1);
    end else if (!issue_s && i_credit_ret) begin
      if (credits_q == CRW'(CREDITS)) begin
        err_d = 1'b1;
      end else begin
        credits_d = credits_q + CRW'(1);
      end
    end else begin
      credits_d = credits_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= W_LOAD;
      cnt_q     <= '0;
      credits_q <= CRW'(CREDITS);
      reload_q  <= 1'b0;
      err_q     <= 1'b0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      credits_q <= credits_d;
      reload_q  <= reload_d;
      err_q     <= err_d;
      live_q    <= 1'b1;
    end
  end

  // Beat packing into the weight and activation vectors.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wvec_q <= '0;
      avec_q <= '0;
    end else begin
      if (w_hs_s) begin
        wvec_q[cnt_q*CHUNKW +: CHUNKW] <= w_data;
      end
      if (a_hs_s) begin
        avec_q[cnt_q*CHUNKW +: CHUNKW] <= a_data;
      end
    end
  end

  // Hold copy of the last issued operands so outputs stay stable between issues.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dataa_q <= '0;
      datab_q <= '0;
    end else if (issue_s) begin
      dataa_q <= avec_q;
      datab_q <= wvec_q;
    end
  end

  assign w_ready      = w_ready_s;
  assign a_ready      = a_ready_s;
  assign o_valid      = issue_s;
  assign o_dataa      = issue_s ? avec_q : dataa_q;
  assign o_datab      = issue_s ? wvec_q : datab_q;
  assign o_credits    = credits_q;
  assign o_credit_err = err_q;

endmodule

// File: tb/tb_dpe_operand_feeder.sv
// Directed self-checking bench for dpe_operand_feeder.
module tb_dpe_operand_feeder;

  logic         clk, rst;
  logic         w_valid, w_ready, w_reload;
  logic [63:0]  w_data;
  logic         a_valid, a_ready;
  logic [63:0]  a_data;
  logic         i_credit_ret;
  logic         o_valid;
  logic [511:0] o_dataa, o_datab;
  logic [3:0]   o_credits;
  logic         o_credit_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int issue_cyc[$];

  dpe_operand_feeder dut (
    .clk(clk), .rst(rst),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_reload(w_reload),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .i_credit_ret(i_credit_ret),
    .o_valid(o_valid), .o_dataa(o_dataa), .o_datab(o_datab),
    .o_credits(o_credits), .o_credit_err(o_credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every issue pulse must coincide with a nonzero credit count.
  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      issue_cyc.push_back(cyc);
      checks++;
      if (o_credits === 4'd0) begin
        errors++;
        $display("FAIL issue_no_credit got credits=%0d need >0", o_credits);
      end
    end
  end

  function automatic logic [511:0] pack(input logic [63:0] base);
    logic [511:0] v;
    for (int k = 0; k < 8; k++) v[k*64 +: 64] = base + 64'(k);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_w(input logic [63:0] d);
    bit ok;
    ok = 1'b0;
    w_valid = 1'b1;
    w_data = d;
    for (int n = 0; n < 200 && !ok; n++) begin
      #1;
      if (w_ready === 1'b1) ok = 1'b1;
      step();
    end
    w_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL w_handshake_timeout got no w_ready need w_ready=1");
    end
  endtask

  task automatic send_a(input logic [63:0] d, input logic rl);
    bit ok;
    ok = 1'b0;
    a_valid = 1'b1;
    a_data = d;
    w_reload = rl;
    for (int n = 0; n < 200 && !ok; n++) begin
      #1;
      if (a_ready === 1'b1) ok = 1'b1;
      step();
    end
    a_valid = 1'b0;
    w_reload = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL a_handshake_timeout got no a_ready need a_ready=1");
    end
  endtask

  task automatic load_w(input logic [63:0] base);
    for (int k = 0; k < 8; k++) send_w(base + 64'(k));
  endtask

  task automatic load_a(input logic [63:0] base);
    for (int k = 0; k < 8; k++) send_a(base + 64'(k), 1'b0);
  endtask

  task automatic ret_credits(input int n);
    for (int i = 0; i < n; i++) begin
      i_credit_ret = 1'b1;
      step();
    end
    i_credit_ret = 1'b0;
  endtask

  task automatic chk_issue(input string nm, input logic [511:0] ea, input logic [511:0] eb);
    #1;
    checks++;
    if (o_valid !== 1'b1) begin
      errors++; $display("FAIL %s_valid got %b need 1", nm, o_valid);
    end
    checks++;
    if (o_dataa !== ea) begin
      errors++; $display("FAIL %s_dataa got %h need %h", nm, o_dataa, ea);
    end
    checks++;
    if (o_datab !== eb) begin
      errors++; $display("FAIL %s_datab got %h need %h", nm, o_datab, eb);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3 rst = 1'b0;
    step(); step();
    #1;
    checks++;
    if ({o_valid, w_ready, a_ready, o_credit_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got %b need 0000", {o_valid, w_ready, a_ready, o_credit_err});
    end
    checks++;
    if (o_credits !== 4'd8) begin
      errors++; $display("FAIL reset_credits got %0d need 8", o_credits);
    end
    checks++;
    if (o_dataa !== 512'd0 || o_datab !== 512'd0) begin
      errors++; $display("FAIL reset_data got a=%h b=%h need 0", o_dataa, o_datab);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (w_ready !== 1'b0) begin
      errors++; $display("FAIL reset_wready_early got %b need 0", w_ready);
    end
    step();
    #1;
    checks++;
    if (w_ready !== 1'b1) begin
      errors++; $display("FAIL reset_wready_live got %b need 1", w_ready);
    end
  endtask

  task automatic test_basic();
    logic [511:0] e;
    load_w(64'h01);
    load_a(64'h10);
    e = pack(64'h10);
    #1;
    checks++;
    if (o_valid !== 1'b1 || o_datab[63:0] !== 64'h01 || o_datab[511:448] !== 64'h08 ||
        o_dataa[63:0] !== 64'h10) begin
      errors++;
      $display("FAIL basic_issue got v=%b b0=%h b7=%h a0=%h need 1 01 08 10",
               o_valid, o_datab[63:0], o_datab[511:448], o_dataa[63:0]);
    end
    checks++;
    if (o_dataa !== e) begin
      errors++; $display("FAIL basic_dataa got %h need %h", o_dataa, e);
    end
    step();
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_credits !== 4'd7) begin
      errors++; $display("FAIL basic_after got v=%b cr=%0d need 0 7", o_valid, o_credits);
    end
    checks++;
    if (o_dataa !== e) begin
      errors++; $display("FAIL basic_hold got %h need %h", o_dataa, e);
    end
  endtask

  task automatic test_credit_starve();
    int n0;
    ret_credits(1);
    n0 = issue_cyc.size();
    for (int v = 0; v < 9; v++) load_a(64'h20 + 64'(v * 8));
    #1;
    checks++;
    if (issue_cyc.size() - n0 !== 8 || o_credits !== 4'd0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL starve_count got issues=%0d cr=%0d v=%b need 8 0 0",
               issue_cyc.size() - n0, o_credits, o_valid);
    end
    for (int i = n0; i < n0 + 7 && i + 1 < issue_cyc.size(); i++) begin
      checks++;
      if (issue_cyc[i+1] - issue_cyc[i] !== 9) begin
        errors++; $display("FAIL b2b_spacing got %0d need 9", issue_cyc[i+1] - issue_cyc[i]);
      end
    end
    a_valid = 1'b1;
    step(); step();
    #1;
    checks++;
    if (a_ready !== 1'b0 || o_valid !== 1'b0) begin
      errors++; $display("FAIL starve_wait got ar=%b v=%b need 0 0", a_ready, o_valid);
    end
    a_valid = 1'b0;
    ret_credits(1);
    chk_issue("starve_ninth", pack(64'h60), pack(64'h01));
    step();
    #1;
    checks++;
    if (o_credits !== 4'd0 || issue_cyc.size() - n0 !== 9) begin
      errors++; $display("FAIL starve_final got cr=%0d issues=%0d need 0 9",
                         o_credits, issue_cyc.size() - n0);
    end
  endtask

  task automatic test_reload();
    int n0;
    ret_credits(4);
    for (int k = 0; k < 8; k++) send_a(64'h70 + 64'(k), (k == 3) ? 1'b1 : 1'b0);
    chk_issue("reload_old_w", pack(64'h70), pack(64'h01));
    step();
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (a_ready !== 1'b0 || w_ready !== 1'b1) begin
        errors++; $display("FAIL reload_wload k=%0d got ar=%b wr=%b need 0 1", k, a_ready, w_ready);
      end
      send_w(64'h80 + 64'(k));
    end
    load_a(64'h90);
    chk_issue("reload_new_w", pack(64'h90), pack(64'h80));
    step();
    n0 = issue_cyc.size();
    a_valid = 1'b1;
    w_reload = 1'b1;
    #1;
    checks++;
    if (a_ready !== 1'b0) begin
      errors++; $display("FAIL reload_cnt0_aready got %b need 0", a_ready);
    end
    step();
    a_valid = 1'b0;
    w_reload = 1'b0;
    #1;
    checks++;
    if (w_ready !== 1'b1 || a_ready !== 1'b0 || issue_cyc.size() !== n0) begin
      errors++; $display("FAIL reload_cnt0_state got wr=%b ar=%b need 1 0", w_ready, a_ready);
    end
  endtask

  task automatic test_credits();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    load_w(64'h100);
    for (int v = 0; v < 3; v++) load_a(64'h200 + 64'(v * 16));
    step();
    #1;
    checks++;
    if (o_credits !== 4'd5) begin
      errors++; $display("FAIL credits_five got %0d need 5", o_credits);
    end
    load_a(64'h300);
    i_credit_ret = 1'b1;
    chk_issue("credits_same", pack(64'h300), pack(64'h100));
    step();
    i_credit_ret = 1'b0;
    #1;
    checks++;
    if (o_credits !== 4'd5) begin
      errors++; $display("FAIL credits_same_cycle got %0d need 5", o_credits);
    end
    ret_credits(3);
    #1;
    checks++;
    if (o_credits !== 4'd8 || o_credit_err !== 1'b0) begin
      errors++; $display("FAIL credits_full got cr=%0d err=%b need 8 0", o_credits, o_credit_err);
    end
    ret_credits(1);
    #1;
    checks++;
    if (o_credits !== 4'd8 || o_credit_err !== 1'b1) begin
      errors++; $display("FAIL credits_over got cr=%0d err=%b need 8 1", o_credits, o_credit_err);
    end
    step(); step(); step();
    #1;
    checks++;
    if (o_credit_err !== 1'b1) begin
      errors++; $display("FAIL credits_sticky got %b need 1", o_credit_err);
    end
  endtask

  task automatic test_gaps();
    logic [63:0]  wb[8];
    logic [63:0]  ab[8];
    logic [511:0] ew, ea;
    w_reload = 1'b1;
    step();
    w_reload = 1'b0;
    for (int v = 0; v < 3; v++) begin
      for (int k = 0; k < 8; k++) begin
        ab[k] = {$urandom(), $urandom()};
        ea[k*64 +: 64] = ab[k];
        if (v == 0) begin
          wb[k] = {$urandom(), $urandom()};
          ew[k*64 +: 64] = wb[k];
        end
      end
      if (v == 0) begin
        a_valid = 1'b1;
        a_data = ab[0];
        for (int k = 0; k < 8; k++) begin
          for (int g = $urandom_range(0, 2); g > 0; g--) step();
          send_w(wb[k]);
          a_valid = 1'b1;
        end
      end
      for (int k = 0; k < 8; k++) begin
        if (k != 0) begin
          for (int g = $urandom_range(0, 2); g > 0; g--) step();
        end
        send_a(ab[k], 1'b0);
      end
      chk_issue("gaps_ref", ea, ew);
      step();
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 5; k++) send_a(64'h500 + 64'(k), 1'b0);
    a_valid = 1'b1;
    a_data = 64'h505;
    rst = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_credits !== 4'd8 || w_ready !== 1'b0 || a_ready !== 1'b0) begin
      errors++; $display("FAIL midrst_state got v=%b cr=%0d wr=%b ar=%b need 0 8 0 0",
                         o_valid, o_credits, w_ready, a_ready);
    end
    a_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    #1;
    checks++;
    if (w_ready !== 1'b1 || a_ready !== 1'b0) begin
      errors++; $display("FAIL midrst_wload got wr=%b ar=%b need 1 0", w_ready, a_ready);
    end
    load_w(64'h600);
    load_a(64'h700);
    chk_issue("midrst_issue", pack(64'h700), pack(64'h600));
    step();
    #1;
    checks++;
    if (o_credits !== 4'd7) begin
      errors++; $display("FAIL midrst_credits got %0d need 7", o_credits);
    end
  endtask

  initial begin
    rst = 1'b1;
    w_valid = 1'b0; w_data = 64'd0; w_reload = 1'b0;
    a_valid = 1'b0; a_data = 64'd0; i_credit_ret = 1'b0;
    test_reset();
    test_basic();
    test_credit_starve();
    test_reload();
    test_credits();
    test_gaps();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
